// File: rtl/button_event_queue_pkg.sv
// Shared constants and the event-entry type for the button event queue.
package button_pkg;
   localparam int BTN_CODE_W          = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_FIFO_DEPTH      = 4;

   typedef struct packed {
      logic                  is_release;
      logic [BTN_CODE_W-1:0] code;
   } ev_entry_t;
endpackage

// File: rtl/button_event_queue_if.sv
// Event handshake toward the lock: one head event at a time, valid/ready.
interface button_event_queue_if #(
   parameter int N_BTN = 4
);
   logic                              ev_valid;
   logic                              ev_ready;
   logic [button_pkg::BTN_CODE_W-1:0] ev_code;
   logic [N_BTN-1:0]                  ev_onehot;
   logic                              ev_release;

   modport master (output ev_valid, ev_code, ev_onehot, ev_release, input ev_ready);
   modport slave  (input ev_valid, ev_code, ev_onehot, ev_release, output ev_ready);
endinterface

// File: rtl/button_event_queue_debounce_channel.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic chg
);
   logic             sync1;
   logic             s;
   logic [CNT_W-1:0] cnt;

   // chg fires on the edge where level toggles; level still holds the old value then.
   assign chg = (s != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         s     <= sync1;
         if (s == level) begin
            cnt <= '0;
         end else if (chg) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/button_event_queue.sv
// Debounced button events queued in a small FIFO with valid/ready output.
// Define BTN_RELEASE_EVENT_EN to also queue release events.
module button_event_queue import button_pkg::*; #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 16,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_BTN-1:0]              btn_raw,
   input  logic                          clr_ovf,
   button_event_queue_if.master          ev,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [N_BTN-1:0]      level;
   logic [N_BTN-1:0]      chg;
   logic [N_BTN-1:0]      press;
   logic [N_BTN-1:0]      pend;
   logic [N_BTN-1:0]      grant;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic                  drop;
   logic [BTN_CODE_W-1:0] push_code;
   logic [BTN_CODE_W-1:0] head_code;
   logic                  head_rel;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_raw[i]),
         .level   (level[i]),
         .chg     (chg[i])
      );
   end

   assign press = chg & ~level;
   assign full  = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
   assign empty = (fifo_count == '0);
   assign pop   = ~empty & ev.ev_ready;

`ifdef BTN_RELEASE_EVENT_EN
   logic [N_BTN-1:0] fall;
   logic [N_BTN-1:0] pend_rel;
   logic [N_BTN-1:0] grant_rel;
   logic             push_rel;
   ev_entry_t        mem [FIFO_DEPTH];
   ev_entry_t        head;

   assign fall     = chg & level;
   assign drop     = |(press & pend) | |(fall & pend_rel);
   assign head     = mem[rd_ptr];
   assign head_code = head.code;
   assign head_rel  = head.is_release;
`else
   logic [BTN_CODE_W-1:0] mem [FIFO_DEPTH];

   assign drop      = |(press & pend);
   assign head_code = mem[rd_ptr];
   assign head_rel  = 1'b0;
`endif

   // Lowest index wins: the descending scan leaves the lowest pending bit granted.
   always_comb begin
      push      = 1'b0;
      grant     = '0;
      push_code = '0;
`ifdef BTN_RELEASE_EVENT_EN
      grant_rel = '0;
      push_rel  = 1'b0;
`endif
      if (!full) begin
         for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
               grant     = '0;
               grant[i]  = 1'b1;
               push      = 1'b1;
               push_code = BTN_CODE_W'(i);
            end
         end
`ifdef BTN_RELEASE_EVENT_EN
         if (!push) begin
            for (int i = N_BTN - 1; i >= 0; i--) begin
               if (pend_rel[i]) begin
                  grant_rel    = '0;
                  grant_rel[i] = 1'b1;
                  push_rel     = 1'b1;
                  push_code    = BTN_CODE_W'(i);
               end
            end
            push = push_rel;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
`ifdef BTN_RELEASE_EVENT_EN
         pend_rel   <= '0;
`endif
      end else begin
         pend <= (pend & ~grant) | (press & ~pend);
`ifdef BTN_RELEASE_EVENT_EN
         pend_rel <= (pend_rel & ~grant_rel) | (fall & ~pend_rel);
`endif
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   // Storage is not reset; empty pointers keep the stale contents invisible.
   always_ff @(posedge clk) begin
      if (push) begin
`ifdef BTN_RELEASE_EVENT_EN
         mem[wr_ptr] <= '{is_release: push_rel, code: push_code};
`else
         mem[wr_ptr] <= push_code;
`endif
      end
   end

   assign ev.ev_valid   = ~empty;
   assign ev.ev_code    = head_code;
   assign ev.ev_release = head_rel;
   assign ev.ev_onehot  = (pop && !head_rel) ? (N_BTN'(1) << head_code) : '0;
endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue with a short debounce window.
module tb_button_event_queue;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_raw = '0;
   logic       clr_ovf = 1'b0;
   logic       overflow;
   logic [2:0] fifo_count;
   int         n_vec = 0;
   int         n_miss = 0;

   button_event_queue_if #(.N_BTN(4)) evif ();

   button_event_queue #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (16),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .clr_ovf    (clr_ovf),
      .ev         (evif),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int b);
      btn_raw[b] = 1'b1;
      tick(DB + 3);
      btn_raw[b] = 1'b0;
      tick(DB + 3);
   endtask

   initial begin
      int exp_seq [6];
      exp_seq = '{1, 2, 3, 0, 1, 2};
      evif.ev_ready = 1'b0;
      tick(2);
      chk("rst_valid", evif.ev_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_onehot", evif.ev_onehot, 0);
      rst_n = 1'b1;
      tick(3);

`ifdef BTN_RELEASE_EVENT_EN
      btn_raw[0] = 1'b1;
      tick(DB + 3);
      btn_raw[0] = 1'b0;
      tick(DB + 4);
      chk("rel_count", fifo_count, 2);
      evif.ev_ready = 1'b1;
      #1;
      chk("rel_code0", evif.ev_code, 0);
      chk("rel_flag0", evif.ev_release, 0);
      chk("rel_onehot0", evif.ev_onehot, 4'b0001);
      tick(1);
      chk("rel_code1", evif.ev_code, 0);
      chk("rel_flag1", evif.ev_release, 1);
      chk("rel_onehot1", evif.ev_onehot, 0);
      tick(1);
      chk("rel_empty", fifo_count, 0);
      evif.ev_ready = 1'b0;
`else
      // press btn 2 held from edge 0
      btn_raw[2] = 1'b1;
      tick(6);
      chk("lat_valid_e5", evif.ev_valid, 0);
      tick(1);
      chk("lat_valid_e6", evif.ev_valid, 1);
      chk("lat_code", evif.ev_code, 2);
      chk("lat_count", fifo_count, 1);
      chk("lat_release", evif.ev_release, 0);
      chk("onehot_idle", evif.ev_onehot, 0);
      evif.ev_ready = 1'b1;
      #1;
      chk("onehot_pop", evif.ev_onehot, 4'b0100);
      tick(1);
      chk("pop_valid", evif.ev_valid, 0);
      chk("pop_count", fifo_count, 0);
      chk("pop_onehot", evif.ev_onehot, 0);
      evif.ev_ready = 1'b0;
      btn_raw[2] = 1'b0;
      tick(10);
      chk("release_noev", fifo_count, 0);

      // glitch on btn 1
      btn_raw[1] = 1'b1;
      tick(3);
      btn_raw[1] = 1'b0;
      tick(12);
      chk("glitch_count", fifo_count, 0);
      chk("glitch_valid", evif.ev_valid, 0);

      // simultaneous press of 0 and 3
      btn_raw = 4'b1001;
      tick(7);
      chk("dual_count1", fifo_count, 1);
      chk("dual_head1", evif.ev_code, 0);
      tick(1);
      chk("dual_count2", fifo_count, 2);
      chk("dual_head2", evif.ev_code, 0);
      evif.ev_ready = 1'b1;
      #1;
      chk("dual_oh0", evif.ev_onehot, 4'b0001);
      tick(1);
      chk("dual_code3", evif.ev_code, 3);
      chk("dual_oh3", evif.ev_onehot, 4'b1000);
      tick(1);
      chk("dual_empty", fifo_count, 0);
      evif.ev_ready = 1'b0;
      btn_raw = 4'b0000;
      tick(10);

      // fill, pend, overflow, drain
      press(1); press(2); press(3); press(0);
      chk("full_count", fifo_count, 4);
      press(1); press(2);
      chk("full_hold", fifo_count, 4);
      chk("ovf_pre", overflow, 0);
      press(1);
      chk("ovf_set", overflow, 1);
      evif.ev_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         #1;
         chk($sformatf("drain_valid%0d", j), evif.ev_valid, 1);
         chk($sformatf("drain_code%0d", j), evif.ev_code, exp_seq[j]);
         tick(1);
      end
      chk("drain_empty", fifo_count, 0);
      evif.ev_ready = 1'b0;
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      chk("ovf_clr", overflow, 0);

      // reset with two queued and one mid-debounce
      press(0); press(1);
      chk("pre_rst_count", fifo_count, 2);
      btn_raw[2] = 1'b1;
      tick(3);
      evif.ev_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", evif.ev_valid, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_onehot", evif.ev_onehot, 0);
      chk("arst_ovf", overflow, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      btn_raw[2] = 1'b0;
      tick(12);
      chk("post_rst_count", fifo_count, 0);
      chk("post_rst_valid", evif.ev_valid, 0);
      evif.ev_ready = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
